invader_formation_ctl: RTL and testbench
========================================

// Module: invader_formation_ctl
// PURPOSE
//  Sequences the invader formation: generates per-column X positions and the formation Y base
//  that the collision block consumes, stepping the whole grid on frame ticks.
//  Reads the alive mask produced by collision detection to find the live edges, speed up as
//  invaders die, detect wave clear, and react to player_hit (game over).
//  Sits between the game top-level (frame tick, start button) and the collision/draw datapath.
// PARAMETERS
//  NUM_INVADERS   10    columns per row
//  NUM_ROWS       3     rows in formation
//  COL_SPACING    80    px between column origins
//  INVADER_WIDTH  64    invader sprite width, px
//  X_START        64    x_base after reset/respawn
//  Y_START        64    enemy_ypos after reset/respawn
//  X_MIN          0     left playfield limit, px
//  X_MAX          1024  right playfield limit (HOR_PIXELS), px
//  STEP_X         8     horizontal step, px
//  STEP_Y         16    vertical drop at an edge, px
//  TICK_BASE      30    frames per step with full formation
//  TICK_MIN       4     minimum frames per step
//  KILL_DIV       2     kills per 1-frame speed-up
//  WAVE_PAUSE     60    frames held in WAVE_CLEAR
// PORTS
//  clk                  in   1                 system clock
//  rst_n                in   1                 reset, synchronous, active-low
//  frame_tick           in   1                 1-cycle pulse per video frame
//  start                in   1                 1-cycle start/restart request
//  alive                in   [NUM_ROWS-1:0][NUM_INVADERS-1:0]  1 = invader alive
//  player_hit           in   1                 level, invaders reached player line
//  invader_x_positions  out  [NUM_INVADERS-1:0][11:0]  column X origins
//  enemy_ypos           out  10                Y of row 0
//  dir_right            out  1                 1 = marching right
//  step                 out  1                 1-cycle pulse on every formation move
//  respawn              out  1                 1-cycle pulse: reload alive mask to all-ones
//  wave_clear           out  1                 1-cycle pulse on entering WAVE_CLEAR
//  game_over            out  1                 level, high while in GAME_OVER
//  wave_num             out  4                 waves cleared, saturates at 15
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low. All outputs registered.
//  - Reset: state IDLE, x_base=X_START, enemy_ypos=Y_START, dir_right=1, step=0, respawn=0,
//    wave_clear=0, game_over=0, wave_num=0, frame counter=0.
//  - invader_x_positions[c] = (x_base + c*COL_SPACING)[11:0]; x_base 13-bit signed internally.
//  - States: IDLE, MARCH, WAVE_CLEAR, GAME_OVER.
//    IDLE: start -> reload positions, dir_right=1, pulse respawn, -> MARCH.
//    MARCH: count frame_tick; when count >= period-1 on a tick -> move, count=0, pulse step.
//      Move: L/R = lowest/highest live column index (OR over rows).
//      Right: if x_base+R*COL_SPACING+INVADER_WIDTH+STEP_X > X_MAX -> enemy_ypos+=STEP_Y,
//        dir_right=0 (no X move), else x_base+=STEP_X. Left: if x_base+L*COL_SPACING < X_MIN+STEP_X
//        -> enemy_ypos+=STEP_Y, dir_right=1, else x_base-=STEP_X.
//      alive==0 -> WAVE_CLEAR, pulse wave_clear, wave_num++ (saturating).
//      player_hit -> GAME_OVER. player_hit and alive==0 same cycle: GAME_OVER wins.
//    WAVE_CLEAR: count WAVE_PAUSE ticks, then reload positions, pulse respawn -> MARCH.
//    GAME_OVER: game_over=1, positions frozen; start -> same as IDLE start (wave_num=0).
//  - period = max(TICK_MIN, TICK_BASE - kills/KILL_DIV), kills = NUM_ROWS*NUM_INVADERS - popcount(alive);
//    popcount/L/R registered (1-cycle lag allowed); use >= so a shrinking period never misses.
//  - start in MARCH/WAVE_CLEAR ignored. frame_tick outside MARCH/WAVE_CLEAR ignored.
//  - No move occurs in the cycle respawn pulses; the alive mask may still read stale for 1 cycle,
//    so alive==0 is not evaluated in the cycle after respawn.
//  - rst_n low mid-march: all state returns to reset values next edge.
// STRUCTURE
//  - invaders_pkg: typedef enum logic [1:0] formation_state_t {IDLE,MARCH,WAVE_CLEAR,GAME_OVER};
//    shared formation constants (COL_SPACING, STEP_X, STEP_Y, X_START, Y_START).
//  - Sub-module alive_scan: registered popcount + lowest/highest live column of alive mask.
// TESTING
//  1. Reset, start, all alive, 30 ticks -> one step, x_base 64->72, respawn pulsed once at start.
//  2. All alive, 22 steps -> x_base=240; next step -> enemy_ypos 64->80, dir_right=0, x unchanged.
//  3. Kill columns 8,9 -> right edge uses R=7: drop happens at x_base=400 (400+560+64+8>1024).
//  4. Kill 20 invaders -> steps every 20 frames; leave 1 alive -> every 16; TICK_BASE=10 -> clamps at 4.
//  5. Clear all alive -> wave_clear pulse, wave_num=1, 60 ticks later respawn pulse, positions reloaded.
//  6. player_hit with alive==0 same cycle -> GAME_OVER, game_over=1; start -> MARCH, wave_num=0.

Source files
------------

// File: rtl/invaders_pkg.sv
// Shared types and geometry constants for the invader formation sequencer.
package invaders_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MARCH      = 2'd1,
    WAVE_CLEAR = 2'd2,
    GAME_OVER  = 2'd3
  } formation_state_t;

  localparam int COL_SPACING = 80;
  localparam int STEP_X      = 8;
  localparam int STEP_Y      = 16;
  localparam int X_START     = 64;
  localparam int Y_START     = 64;

endpackage

// File: rtl/alive_scan.sv
// Registered summary of the alive mask: live count, lowest and highest live column, non-empty.
module alive_scan #(
  parameter int NUM_INVADERS = 10,
  parameter int NUM_ROWS     = 3,
  parameter int CNT_W        = 5,
  parameter int COL_W        = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_ROWS-1:0][NUM_INVADERS-1:0]   alive,
  output logic [CNT_W-1:0]                        count,
  output logic [COL_W-1:0]                        lo,
  output logic [COL_W-1:0]                        hi,
  output logic                                    nonzero
);

  logic [NUM_INVADERS-1:0] col_live;
  logic [CNT_W-1:0]        count_c;
  logic [COL_W-1:0]        lo_c;
  logic [COL_W-1:0]        hi_c;

  always_comb begin
    col_live = '0;
    count_c  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      col_live = col_live | alive[r];
      for (int c = 0; c < NUM_INVADERS; c++) begin
        count_c = count_c + {{(CNT_W-1){1'b0}}, alive[r][c]};
      end
    end
  end

  // Opposite scan directions so the last hit is the extreme live column.
  always_comb begin
    lo_c = '0;
    hi_c = '0;
    for (int c = NUM_INVADERS - 1; c >= 0; c--) begin
      if (col_live[c]) lo_c = COL_W'(c);
    end
    for (int c = 0; c < NUM_INVADERS; c++) begin
      if (col_live[c]) hi_c = COL_W'(c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      lo      <= '0;
      hi      <= '0;
      nonzero <= 1'b0;
    end else begin
      count   <= count_c;
      lo      <= lo_c;
      hi      <= hi_c;
      nonzero <= |col_live;
    end
  end

endmodule

// File: rtl/invader_formation_ctl.sv
// Invader formation sequencer: marches the grid on frame ticks, speeds up with kills,
// handles wave clear and game over.
module invader_formation_ctl import invaders_pkg::*; #(
  parameter int NUM_INVADERS  = 10,
  parameter int NUM_ROWS      = 3,
  parameter int COL_SPACING   = invaders_pkg::COL_SPACING,
  parameter int INVADER_WIDTH = 64,
  parameter int X_START       = invaders_pkg::X_START,
  parameter int Y_START       = invaders_pkg::Y_START,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 1024,
  parameter int STEP_X        = invaders_pkg::STEP_X,
  parameter int STEP_Y        = invaders_pkg::STEP_Y,
  parameter int TICK_BASE     = 30,
  parameter int TICK_MIN      = 4,
  parameter int KILL_DIV      = 2,
  parameter int WAVE_PAUSE    = 60
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    frame_tick,
  input  logic                                    start,
  input  logic [NUM_ROWS-1:0][NUM_INVADERS-1:0]   alive,
  input  logic                                    player_hit,
  output logic [NUM_INVADERS-1:0][11:0]           invader_x_positions,
  output logic [9:0]                              enemy_ypos,
  output logic                                    dir_right,
  output logic                                    step,
  output logic                                    respawn,
  output logic                                    wave_clear,
  output logic                                    game_over,
  output logic [3:0]                              wave_num
);

  localparam int Total     = NUM_ROWS * NUM_INVADERS;
  localparam int CntW      = $clog2(Total + 1);
  localparam int ColW      = (NUM_INVADERS > 1) ? $clog2(NUM_INVADERS) : 1;
  localparam int FrameMax  = (TICK_BASE > WAVE_PAUSE) ? TICK_BASE : WAVE_PAUSE;
  localparam int FrameW    = $clog2(FrameMax + 1);

  formation_state_t state_q, state_d;
  logic signed [12:0]             x_base_q, x_base_d;
  logic [9:0]                     ypos_q, ypos_d;
  logic                           dir_q, dir_d;
  logic                           step_q, step_d;
  logic                           respawn_q, respawn_d;
  logic                           wave_clear_q, wave_clear_d;
  logic                           game_over_q;
  logic [3:0]                     wave_q, wave_d;
  logic [FrameW-1:0]              frame_q, frame_d;
  logic                           settle_q;
  logic [NUM_INVADERS-1:0][11:0]  xpos_q, xpos_d;

  logic [CntW-1:0] live_cnt;
  logic [ColW-1:0] live_lo, live_hi;
  logic            live_any;

  alive_scan #(
    .NUM_INVADERS (NUM_INVADERS),
    .NUM_ROWS     (NUM_ROWS),
    .CNT_W        (CntW),
    .COL_W        (ColW)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .alive   (alive),
    .count   (live_cnt),
    .lo      (live_lo),
    .hi      (live_hi),
    .nonzero (live_any)
  );

  int kills, period_raw, period, right_edge, left_edge;
  logic hold;

  assign kills      = Total - int'(live_cnt);
  assign period_raw = TICK_BASE - kills / KILL_DIV;
  assign period     = (period_raw < TICK_MIN) ? TICK_MIN : period_raw;
  assign right_edge = int'(x_base_q) + int'(live_hi) * COL_SPACING + INVADER_WIDTH + STEP_X;
  assign left_edge  = int'(x_base_q) + int'(live_lo) * COL_SPACING;
  // Scan output is stale during the respawn cycle and the one after it.
  assign hold       = respawn_q | settle_q;

  always_comb begin
    state_d      = state_q;
    x_base_d     = x_base_q;
    ypos_d       = ypos_q;
    dir_d        = dir_q;
    step_d       = 1'b0;
    respawn_d    = 1'b0;
    wave_clear_d = 1'b0;
    wave_d       = wave_q;
    frame_d      = frame_q;
    unique case (state_q)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_d   = MARCH;
          x_base_d  = 13'(X_START);
          ypos_d    = 10'(Y_START);
          dir_d     = 1'b1;
          respawn_d = 1'b1;
          frame_d   = '0;
          wave_d    = '0;
        end
      end
      MARCH: begin
        if (player_hit) begin
          state_d = GAME_OVER;
        end else if (!hold && !live_any) begin
          state_d      = WAVE_CLEAR;
          wave_clear_d = 1'b1;
          wave_d       = (wave_q == 4'hF) ? wave_q : wave_q + 4'd1;
          frame_d      = '0;
        end else if (!hold && frame_tick) begin
          if (int'(frame_q) >= period - 1) begin
            frame_d = '0;
            step_d  = 1'b1;
            if (dir_q) begin
              if (right_edge > X_MAX) begin
                ypos_d = ypos_q + 10'(STEP_Y);
                dir_d  = 1'b0;
              end else begin
                x_base_d = x_base_q + 13'(STEP_X);
              end
            end else begin
              if (left_edge < X_MIN + STEP_X) begin
                ypos_d = ypos_q + 10'(STEP_Y);
                dir_d  = 1'b1;
              end else begin
                x_base_d = x_base_q - 13'(STEP_X);
              end
            end
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      WAVE_CLEAR: begin
        if (frame_tick) begin
          if (int'(frame_q) >= WAVE_PAUSE - 1) begin
            state_d   = MARCH;
            x_base_d  = 13'(X_START);
            ypos_d    = 10'(Y_START);
            dir_d     = 1'b1;
            respawn_d = 1'b1;
            frame_d   = '0;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    for (int c = 0; c < NUM_INVADERS; c++) begin
      xpos_d[c] = x_base_d[11:0] + 12'(c * COL_SPACING);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_base_q     <= 13'(X_START);
      ypos_q       <= 10'(Y_START);
      dir_q        <= 1'b1;
      step_q       <= 1'b0;
      respawn_q    <= 1'b0;
      wave_clear_q <= 1'b0;
      game_over_q  <= 1'b0;
      wave_q       <= '0;
      frame_q      <= '0;
      settle_q     <= 1'b0;
      for (int c = 0; c < NUM_INVADERS; c++) begin
        xpos_q[c] <= 12'(X_START + c * COL_SPACING);
      end
    end else begin
      state_q      <= state_d;
      x_base_q     <= x_base_d;
      ypos_q       <= ypos_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      respawn_q    <= respawn_d;
      wave_clear_q <= wave_clear_d;
      game_over_q  <= (state_d == GAME_OVER);
      wave_q       <= wave_d;
      frame_q      <= frame_d;
      settle_q     <= respawn_q;
      xpos_q       <= xpos_d;
    end
  end

  assign invader_x_positions = xpos_q;
  assign enemy_ypos          = ypos_q;
  assign dir_right           = dir_q;
  assign step                = step_q;
  assign respawn             = respawn_q;
  assign wave_clear          = wave_clear_q;
  assign game_over           = game_over_q;
  assign wave_num            = wave_q;

endmodule

// File: tb/tb_invader_formation_ctl.sv
// Directed bench for invader_formation_ctl: marching, edge drops, speed-up, wave clear, game over.
module tb_invader_formation_ctl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic start = 1'b0;
  logic player_hit = 1'b0;
  logic [2:0][9:0] alive = '1;

  logic [9:0][11:0] xpos, xpos_f;
  logic [9:0] ypos, ypos_f;
  logic dir, dir_f, step, step_f, respawn, respawn_f;
  logic wave_clear, wave_clear_f, game_over, game_over_f;
  logic [3:0] wave_num, wave_num_f;

  int total = 0;
  int bad = 0;
  int step_cnt = 0;
  int fast_step_cnt = 0;
  int respawn_cnt = 0;
  int wave_clear_cnt = 0;

  invader_formation_ctl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .frame_tick          (frame_tick),
    .start               (start),
    .alive               (alive),
    .player_hit          (player_hit),
    .invader_x_positions (xpos),
    .enemy_ypos          (ypos),
    .dir_right           (dir),
    .step                (step),
    .respawn             (respawn),
    .wave_clear          (wave_clear),
    .game_over           (game_over),
    .wave_num            (wave_num)
  );

  // Same formation with a short base period, used only to see the TICK_MIN clamp.
  invader_formation_ctl #(
    .TICK_BASE (10)
  ) dut_fast (
    .clk                 (clk),
    .rst_n               (rst_n),
    .frame_tick          (frame_tick),
    .start               (start),
    .alive               (alive),
    .player_hit          (player_hit),
    .invader_x_positions (xpos_f),
    .enemy_ypos          (ypos_f),
    .dir_right           (dir_f),
    .step                (step_f),
    .respawn             (respawn_f),
    .wave_clear          (wave_clear_f),
    .game_over           (game_over_f),
    .wave_num            (wave_num_f)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step) step_cnt <= step_cnt + 1;
    if (step_f) fast_step_cnt <= fast_step_cnt + 1;
    if (respawn) respawn_cnt <= respawn_cnt + 1;
    if (wave_clear) wave_clear_cnt <= wave_clear_cnt + 1;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // Frames until the selected instance steps; a missing step returns the bound (200).
  task automatic frames_to_step(input bit fast, output int n);
    int c0;
    c0 = fast ? fast_step_cnt : step_cnt;
    n = 0;
    while (((fast ? fast_step_cnt : step_cnt) == c0) && n < 200) begin
      frame();
      n++;
    end
  endtask

  int n, rc, wc, sc;

  initial begin
    // Reset values
    cyc(2);
    check_val("rst_x0", int'(xpos[0]), 64);
    check_val("rst_x9", int'(xpos[9]), 784);
    check_val("rst_y", int'(ypos), 64);
    check_val("rst_dir", int'(dir), 1);
    check_val("rst_pulses", int'({step, respawn, wave_clear, game_over}), 0);
    check_val("rst_wave", int'(wave_num), 0);
    rst_n = 1'b1;
    cyc(1);

    // First step after 30 frames
    pulse_start();
    check_val("start_respawn", int'(respawn), 1);
    cyc(3);
    frames_to_step(1'b0, n);
    check_val("first_period", n, 30);
    check_val("first_x", int'(xpos[0]), 72);
    check_val("respawn_once", respawn_cnt, 1);

    // Full formation reaches the right edge at x_base=240
    repeat (21) frames_to_step(1'b0, n);
    check_val("edge_x", int'(xpos[0]), 240);
    check_val("edge_y_before", int'(ypos), 64);
    frames_to_step(1'b0, n);
    check_val("drop_y", int'(ypos), 80);
    check_val("drop_dir", int'(dir), 0);
    check_val("drop_x", int'(xpos[0]), 240);
    check_val("drop_x9", int'(xpos[9]), 960);
    frames_to_step(1'b0, n);
    check_val("left_x", int'(xpos[0]), 232);

    // Reset mid-march
    rst_n = 1'b0;
    cyc(1);
    check_val("midrst_x", int'(xpos[0]), 64);
    check_val("midrst_y", int'(ypos), 64);
    check_val("midrst_dir", int'(dir), 1);
    rst_n = 1'b1;

    // Columns 8,9 dead: right edge uses column 7, drop at x_base=400
    for (int r = 0; r < 3; r++) alive[r] = 10'h0FF;
    cyc(1);
    pulse_start();
    cyc(3);
    frames_to_step(1'b0, n);
    check_val("period_kill6", n, 27);
    repeat (41) frames_to_step(1'b0, n);
    check_val("r7_x", int'(xpos[0]), 400);
    check_val("r7_y_before", int'(ypos), 64);
    frames_to_step(1'b0, n);
    check_val("r7_drop_y", int'(ypos), 80);
    check_val("r7_drop_x", int'(xpos[0]), 400);
    check_val("r7_drop_dir", int'(dir), 0);

    // Speed-up with kills
    alive = '0;
    alive[0] = 10'h3FF;
    frames_to_step(1'b0, n);
    frames_to_step(1'b0, n);
    check_val("period_kill20", n, 20);
    alive = '0;
    alive[0][5] = 1'b1;
    frames_to_step(1'b0, n);
    frames_to_step(1'b0, n);
    check_val("period_kill29", n, 16);
    frames_to_step(1'b1, n);
    frames_to_step(1'b1, n);
    check_val("period_clamp", n, 4);

    // Wave clear and respawn after the pause
    alive = '0;
    cyc(2);
    check_val("wc_pulse", int'(wave_clear), 1);
    check_val("wc_wave", int'(wave_num), 1);
    cyc(1);
    check_val("wc_pulse_end", int'(wave_clear), 0);
    rc = respawn_cnt;
    repeat (59) frame();
    check_val("wc_no_early_respawn", respawn_cnt, rc);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    check_val("wc_respawn", int'(respawn), 1);
    check_val("wc_reload_x", int'(xpos[0]), 64);
    check_val("wc_reload_y", int'(ypos), 64);
    check_val("wc_reload_dir", int'(dir), 1);
    alive = '1;
    cyc(3);
    check_val("wc_wave_kept", int'(wave_num), 1);

    // player_hit and empty mask reach the FSM together: game over wins
    wc = wave_clear_cnt;
    alive = '0;
    cyc(1);
    player_hit = 1'b1;
    cyc(1);
    player_hit = 1'b0;
    check_val("go_level", int'(game_over), 1);
    cyc(2);
    check_val("go_no_wave_clear", wave_clear_cnt, wc);
    check_val("go_wave", int'(wave_num), 1);
    sc = step_cnt;
    alive = '1;
    repeat (40) frame();
    check_val("go_frozen", step_cnt, sc);
    check_val("go_held", int'(game_over), 1);
    pulse_start();
    check_val("restart_go", int'(game_over), 0);
    check_val("restart_wave", int'(wave_num), 0);
    check_val("restart_respawn", int'(respawn), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
